reg_display_scanner: RTL and testbench
======================================

// Module: reg_display_scanner
// PURPOSE
//  Downstream consumer of the datapath register outputs reg1..reg4 (signed 8-bit).
//  Snapshots one selected register and converts it to sign + 3 BCD digits with a
//  sequential 8-step double-dabble.
//  Time-multiplexes the result onto a 4-digit common-anode 7-segment display.
//  Display content changes only on completed conversions, so it never tears.
// PARAMETERS
//  REFRESH_DIV  16'd50000  clk cycles each digit is driven before advancing scan
//  SAMPLE_DIV   24'd5000000  clk cycles between periodic re-samples of selected reg
// PORTS
//  clk      in   1  system clock, all state on rising edge
//  reset    in   1  asynchronous, active-low reset
//  reg1     in   8  signed register value, sel=0
//  reg2     in   8  signed register value, sel=1
//  reg3     in   8  signed register value, sel=2
//  reg4     in   8  signed register value, sel=3
//  sel      in   2  register to display; sampled every clk
//  an       out  4  digit enables, active-low; an[3] = leftmost (sign) digit
//  seg      out  8  {dp,g,f,e,d,c,b,a}, active-low; dp always off (1)
//  busy     out  1  1 while a conversion is in progress
//  shown    out  2  index of register currently on display
// BEHAVIOUR
//  Reset (reset=0, async):
//   - an=4'b1111, seg=8'hFF, busy=0, shown=0.
//   - Display BCD=000, sign=+; all counters and FSM cleared.
//  Conversion FSM: IDLE -> LOAD -> SHIFT -> DONE -> IDLE.
//   - IDLE: start when the sample counter hits SAMPLE_DIV-1, or when sel != sel_q
//     (sel_q = sel registered last cycle). A request while not IDLE sets a pending
//     flag (one deep). Pending is serviced on the cycle after DONE.
//   - LOAD: v = mux(sel); neg = v[7]; mag = neg ? -v : v, computed in 9 bits so
//     -128 gives 128. Clear the 12-bit BCD accumulator, shift count = 0. busy=1.
//   - SHIFT: 8 cycles. Each cycle, add 3 to every nibble >= 5, then shift
//     {bcd,mag} left by 1.
//   - DONE: copy accumulator, neg and captured sel into display regs atomically.
//     busy=0.
//   - Latency: 11 clk from start request to new digits visible (LOAD + 8 SHIFT +
//     DONE + output register).
//  Scan:
//   - 16-bit refresh counter wraps at REFRESH_DIV-1 and advances digit idx 0->1->2->3->0.
//   - an = ~(4'b0001 << idx), registered; seg is registered in the same cycle as an.
//   - idx3: '-' (seg 8'hBF) if neg, else blank (8'hFF).
//   - idx2: hundreds digit; blank when 0.
//   - idx1: tens digit; blank when hundreds=0 and tens=0.
//   - idx0: ones digit, always shown ("  0" for zero).
//  Boundaries:
//   - -128 shows "-128"; 127 shows " 127"; -1 shows "-  1".
//   - sel change during SHIFT: current conversion completes with the old sel and
//     is displayed, then pending triggers a new conversion with the new sel.
//   - Periodic tick and sel change in the same cycle: one request only.
//   - reset mid-conversion: immediate return to the reset state; no partial digits
//     are ever latched.
// STRUCTURE
//  - Shared include/package: FSM state encodings (2-bit), active-low segment
//    constants SEG_BLANK=8'hFF and SEG_MINUS=8'hBF, and the digit 0-9 code table.
//  - One sub-module: seg7_decoder (4-bit BCD in, 8-bit active-low seg out,
//    purely combinational).
//  - Everything else stays in this module: FSM, double-dabble datapath, both
//    counters, scan mux.
// TESTING (REFRESH_DIV=4, SAMPLE_DIV=64 in bench)
//  1. Hold reset low 5 clk -> an=1111, seg=FF, busy=0. Release -> first scan shows
//     an=1110, seg=C0 ('0').
//  2. reg1=8'sd127, sel=0 -> busy high for exactly 10 clk. Then digits idx3..0 =
//     FF, F9, A4, F8 (" 127").
//  3. reg3=8'h80, sel: 0->2 -> shown=2 after 11 clk. Digits = BF, F9, A4, 80 ("-128").
//  4. reg2=8'hFF, sel=1 -> digits BF, FF, FF, F9 ("-  1"). Leading-zero blanking
//     verified.
//  5. Toggle sel 0->3 on the 3rd SHIFT cycle -> first completion shows reg1, then a
//     second conversion runs. Final shown=3; busy pulses twice with no idle gap
//     >1 clk.
//  6. Assert reset during SHIFT -> outputs return to reset values the same cycle.
//     After release, no stale digits appear before the next conversion.

Source files
------------

// File: rtl/reg_display_scanner_pkg.sv
// rtl/reg_display_scanner_pkg.sv - shared FSM encodings, segment codes and BCD helper
package reg_display_scanner_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_DONE  = 2'd3
  } conv_state_t;

  localparam logic [7:0] SEG_BLANK = 8'hFF;
  localparam logic [7:0] SEG_MINUS = 8'hBF;

  // Active-low {dp,g,f,e,d,c,b,a}; element n is the code for digit n.
  localparam logic [9:0][7:0] SEG_DIGITS = {
    8'h90, 8'h80, 8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0
  };

  // One double-dabble correction: nibbles of 5 or more get +3 before the shift.
  function automatic logic [11:0] dd_adjust(input logic [11:0] bcd);
    logic [11:0] r;
    r = bcd;
    for (int i = 0; i < 3; i++) begin
      if (bcd[4*i +: 4] >= 4'd5) r[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
    end
    return r;
  endfunction

endpackage

// File: rtl/reg_display_scanner_if.sv
// rtl/reg_display_scanner_if.sv - register inputs and display outputs of the scanner
interface reg_display_scanner_if;
  logic signed [7:0] reg1;
  logic signed [7:0] reg2;
  logic signed [7:0] reg3;
  logic signed [7:0] reg4;
  logic [1:0]        sel;
  logic [3:0]        an;
  logic [7:0]        seg;
  logic              busy;
  logic [1:0]        shown;

  modport master (
    output reg1, reg2, reg3, reg4, sel,
    input  an, seg, busy, shown
  );

  modport slave (
    input  reg1, reg2, reg3, reg4, sel,
    output an, seg, busy, shown
  );
endinterface

// File: rtl/reg_display_scanner_seg7_decoder.sv
// rtl/reg_display_scanner_seg7_decoder.sv - BCD digit to active-low 7-segment code
module seg7_decoder
  import reg_display_scanner_pkg::*;
(
  input  logic [3:0] digit,
  output logic [7:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    if (digit <= 4'd9) seg = SEG_DIGITS[digit];
  end

endmodule

// File: rtl/reg_display_scanner.sv
// rtl/reg_display_scanner.sv - snapshot a selected register, convert to sign+BCD, scan 4 digits
module reg_display_scanner
  import reg_display_scanner_pkg::*;
#(
  parameter logic [15:0] REFRESH_DIV = 16'd50000,
  parameter logic [23:0] SAMPLE_DIV  = 24'd5000000
) (
  input logic                  clk,
  input logic                  reset,
  reg_display_scanner_if.slave bus
);

  conv_state_t state, state_n;
  logic        pending, pending_n;
  logic        busy_q, busy_n;
  logic [1:0]  sel_q;
  logic [23:0] sample_cnt;
  logic [15:0] refresh_cnt;
  logic [1:0]  idx;
  logic        sample_tick;
  logic        req;
  logic [7:0]  v;

  logic [11:0] bcd;
  logic [11:0] bcd_adj;
  logic [7:0]  mag;
  logic [2:0]  shift_cnt;
  logic        neg_cap;
  logic [1:0]  sel_cap;

  logic [11:0] disp_bcd;
  logic        disp_neg;
  logic [1:0]  disp_sel;

  logic [3:0]  an_q;
  logic [7:0]  seg_q;
  logic [3:0]  digit;
  logic [7:0]  digit_seg;
  logic [7:0]  seg_n;

  assign sample_tick = (sample_cnt == SAMPLE_DIV - 24'd1);
  assign req         = sample_tick || (bus.sel != sel_q);
  assign bcd_adj     = dd_adjust(bcd);

  always_comb begin
    v = bus.reg1;
    case (bus.sel)
      2'd0: v = bus.reg1;
      2'd1: v = bus.reg2;
      2'd2: v = bus.reg3;
      2'd3: v = bus.reg4;
      default: v = bus.reg1;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= ST_IDLE;
      pending <= 1'b0;
      busy_q  <= 1'b0;
      sel_q   <= 2'd0;
    end else begin
      state   <= state_n;
      pending <= pending_n;
      busy_q  <= busy_n;
      sel_q   <= bus.sel;
    end
  end

  // A request arriving while a conversion runs is remembered once and replayed from IDLE.
  always_comb begin
    state_n   = state;
    pending_n = pending;
    busy_n    = busy_q;
    case (state)
      ST_IDLE: begin
        pending_n = 1'b0;
        if (req || pending) begin
          state_n = ST_LOAD;
          busy_n  = 1'b1;
        end
      end
      ST_LOAD: begin
        state_n = ST_SHIFT;
        if (req) pending_n = 1'b1;
      end
      ST_SHIFT: begin
        if (shift_cnt == 3'd7) state_n = ST_DONE;
        if (req) pending_n = 1'b1;
      end
      ST_DONE: begin
        state_n = ST_IDLE;
        busy_n  = 1'b0;
        if (req) pending_n = 1'b1;
      end
      default: state_n = ST_IDLE;
    endcase
  end

  // Magnitude is formed in 9 bits so that -128 yields 128.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bcd       <= 12'd0;
      mag       <= 8'd0;
      shift_cnt <= 3'd0;
      neg_cap   <= 1'b0;
      sel_cap   <= 2'd0;
    end else begin
      case (state)
        ST_LOAD: begin
          neg_cap   <= v[7];
          mag       <= 8'(v[7] ? 9'd0 - {v[7], v} : {v[7], v});
          bcd       <= 12'd0;
          shift_cnt <= 3'd0;
          sel_cap   <= bus.sel;
        end
        ST_SHIFT: begin
          {bcd, mag} <= {bcd_adj, mag} << 1;
          shift_cnt  <= shift_cnt + 3'd1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      disp_bcd <= 12'd0;
      disp_neg <= 1'b0;
      disp_sel <= 2'd0;
    end else if (state == ST_DONE) begin
      disp_bcd <= bcd;
      disp_neg <= neg_cap;
      disp_sel <= sel_cap;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sample_cnt  <= 24'd0;
      refresh_cnt <= 16'd0;
      idx         <= 2'd0;
    end else begin
      sample_cnt <= sample_tick ? 24'd0 : sample_cnt + 24'd1;
      if (refresh_cnt == REFRESH_DIV - 16'd1) begin
        refresh_cnt <= 16'd0;
        idx         <= idx + 2'd1;
      end else begin
        refresh_cnt <= refresh_cnt + 16'd1;
      end
    end
  end

  always_comb begin
    digit = disp_bcd[3:0];
    case (idx)
      2'd2:    digit = disp_bcd[11:8];
      2'd1:    digit = disp_bcd[7:4];
      default: digit = disp_bcd[3:0];
    endcase
  end

  seg7_decoder u_dec (
    .digit (digit),
    .seg   (digit_seg)
  );

  // Leading-zero blanking: the ones digit is always lit.
  always_comb begin
    seg_n = digit_seg;
    case (idx)
      2'd3: seg_n = disp_neg ? SEG_MINUS : SEG_BLANK;
      2'd2: seg_n = (disp_bcd[11:8] == 4'd0) ? SEG_BLANK : digit_seg;
      2'd1: seg_n = (disp_bcd[11:4] == 8'd0) ? SEG_BLANK : digit_seg;
      default: seg_n = digit_seg;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      an_q  <= 4'b1111;
      seg_q <= SEG_BLANK;
    end else begin
      an_q  <= ~(4'b0001 << idx);
      seg_q <= seg_n;
    end
  end

  assign bus.an    = an_q;
  assign bus.seg   = seg_q;
  assign bus.busy  = busy_q;
  assign bus.shown = disp_sel;

endmodule

// File: tb/tb_reg_display_scanner.sv
// tb/tb_reg_display_scanner.sv - directed and random checks of reg_display_scanner
module tb_reg_display_scanner;

  logic clk = 1'b0;
  logic reset;
  int   vectors = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  reg_display_scanner_if bus();

  reg_display_scanner #(
    .REFRESH_DIV (16'd4),
    .SAMPLE_DIV  (24'd64)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  localparam logic [7:0] DIGIT_SEG [10] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8, 8'h80, 8'h90
  };

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Expected segment code for display position pos (3 = sign) of signed value v.
  function automatic logic [7:0] model_seg(input int v, input int pos);
    int m, h, t, o;
    m = (v < 0) ? -v : v;
    h = m / 100;
    t = (m / 10) % 10;
    o = m % 10;
    case (pos)
      3:       return (v < 0) ? 8'hBF : 8'hFF;
      2:       return (h == 0) ? 8'hFF : DIGIT_SEG[h];
      1:       return (h == 0 && t == 0) ? 8'hFF : DIGIT_SEG[t];
      default: return DIGIT_SEG[o];
    endcase
  endfunction

  function automatic int reg_value(input logic [1:0] s);
    case (s)
      2'd0:    return int'(bus.reg1);
      2'd1:    return int'(bus.reg2);
      2'd2:    return int'(bus.reg3);
      default: return int'(bus.reg4);
    endcase
  endfunction

  task automatic capture(input string tag, input int v);
    logic [7:0] got [4];
    for (int i = 0; i < 4; i++) got[i] = 8'hxx;
    repeat (2) step();
    repeat (40) begin
      @(negedge clk);
      for (int i = 0; i < 4; i++) begin
        if (bus.an === 4'(~(4'b0001 << i))) got[i] = bus.seg;
      end
    end
    for (int i = 0; i < 4; i++)
      check($sformatf("%s_digit%0d", tag, i), 32'(got[i]), 32'(model_seg(v, i)));
  endtask

  task automatic wait_quiet(input string tag);
    int n = 0;
    int quiet = 0;
    bit seen = 1'b0;
    while (n < 300 && !(seen && quiet >= 3)) begin
      step();
      n++;
      if (bus.busy === 1'b1) begin
        seen  = 1'b1;
        quiet = 0;
      end else begin
        quiet++;
      end
    end
    check({tag, "_quiet"}, 32'(seen && quiet >= 3), 32'd1);
  endtask

  task automatic wait_shown(input string tag, input logic [1:0] s);
    int n = 0;
    while (n < 300 && !(bus.shown === s && bus.busy === 1'b0)) begin
      step();
      n++;
    end
    check({tag, "_shown"}, 32'(bus.shown), 32'(s));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, w, rises, gap, max_gap, first_shown;
    logic prev;
    logic [1:0] cur, ns;

    reset    = 1'b0;
    bus.reg1 = 8'sd0;
    bus.reg2 = 8'sd0;
    bus.reg3 = 8'sd0;
    bus.reg4 = 8'sd0;
    bus.sel  = 2'd0;

    repeat (5) @(posedge clk);
    #1;
    check("reset_an",    32'(bus.an),    32'h0000000F);
    check("reset_seg",   32'(bus.seg),   32'h000000FF);
    check("reset_busy",  32'(bus.busy),  32'd0);
    check("reset_shown", 32'(bus.shown), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    step();
    check("first_scan_an",  32'(bus.an),  32'h0000000E);
    check("first_scan_seg", 32'(bus.seg), 32'h000000C0);

    // Periodic re-sample of reg1 = 127
    bus.reg1 = 8'sd127;
    n = 0;
    while (bus.busy !== 1'b1 && n < 200) begin step(); n++; end
    w = 0;
    while (bus.busy === 1'b1 && w < 50) begin step(); w++; end
    check("t2_busy_width", 32'(w), 32'd10);
    check("t2_shown", 32'(bus.shown), 32'd0);
    capture("t2", 127);

    // -128 via sel change, with latency measurement
    bus.reg3 = 8'sh80;
    wait_quiet("t3");
    bus.sel = 2'd2;
    n = 0;
    while (bus.shown !== 2'd2 && n < 50) begin step(); n++; end
    check("t3_latency", 32'(n), 32'd11);
    capture("t3", -128);

    // -1 exercises leading-zero blanking
    bus.reg2 = 8'shFF;
    wait_quiet("t4");
    bus.sel = 2'd1;
    wait_shown("t4", 2'd1);
    capture("t4", -1);

    // sel change on the 3rd SHIFT cycle
    bus.reg4 = 8'($urandom_range(0, 255));
    wait_quiet("t5");
    bus.sel = 2'd0;
    repeat (4) step();
    bus.sel = 2'd3;
    rises = 1;
    prev = bus.busy;
    gap = 0;
    max_gap = 0;
    first_shown = -1;
    repeat (30) begin
      step();
      if (bus.busy === 1'b1) begin
        if (prev !== 1'b1) begin
          rises++;
          if (gap > max_gap) max_gap = gap;
        end
        gap = 0;
      end else begin
        gap++;
      end
      prev = bus.busy;
      if (first_shown < 0 && bus.shown !== 2'd1) first_shown = int'(bus.shown);
    end
    check("t5_busy_pulses", 32'(rises), 32'd2);
    check("t5_idle_gap", 32'(max_gap), 32'd1);
    check("t5_first_shown", 32'(first_shown), 32'd0);
    check("t5_final_shown", 32'(bus.shown), 32'd3);
    capture("t5", reg_value(2'd3));

    // Reset in the middle of a conversion
    wait_quiet("t6");
    bus.sel = 2'd2;
    repeat (4) step();
    reset = 1'b0;
    #1;
    check("t6_reset_an",    32'(bus.an),    32'h0000000F);
    check("t6_reset_seg",   32'(bus.seg),   32'h000000FF);
    check("t6_reset_busy",  32'(bus.busy),  32'd0);
    check("t6_reset_shown", 32'(bus.shown), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    step();
    check("t6_post_an",    32'(bus.an),    32'h0000000E);
    check("t6_post_seg",   32'(bus.seg),   32'h000000C0);
    check("t6_post_shown", 32'(bus.shown), 32'd0);
    wait_shown("t6", 2'd2);
    capture("t6", -128);

    // Random register contents and selections
    cur = 2'd2;
    for (int k = 0; k < 8; k++) begin
      wait_quiet($sformatf("rnd%0d", k));
      bus.reg1 = 8'($urandom_range(0, 255));
      bus.reg2 = 8'($urandom_range(0, 255));
      bus.reg3 = 8'($urandom_range(0, 255));
      bus.reg4 = 8'($urandom_range(0, 255));
      ns = 2'((int'(cur) + 1 + int'($urandom_range(0, 2))) % 4);
      bus.sel = ns;
      wait_shown($sformatf("rnd%0d", k), ns);
      capture($sformatf("rnd%0d", k), reg_value(ns));
      cur = ns;
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
